// File: rtl/fp16_pkg.sv
// Shared fp16 constants, FSM state type and operand unpacking for the float_MAC accumulator.
package fp16_pkg;

  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MAN_W   = 10;
  localparam int FP16_BIAS    = 15;
  localparam int FP16_GUARD_W = 3;
  localparam int FP16_SIG_W   = 1 + FP16_MAN_W + FP16_GUARD_W;
  localparam int FP16_SUM_W   = FP16_SIG_W + 1;

  localparam logic [15:0] FP16_MAX_POS = 16'h7BFF;
  localparam logic [15:0] FP16_INF     = 16'h7C00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } acc_state_t;

  typedef struct packed {
    logic                               sign;
    logic [FP16_EXP_W-1:0]              exp;
    logic [FP16_MAN_W+FP16_GUARD_W:0]   sig;
  } fp16_op_t;

  // Subnormals flush to zero; Inf/NaN inputs behave as the largest finite magnitude.
  function automatic fp16_op_t fp16_unpack(input logic [15:0] v);
    fp16_op_t op;
    op.sign = v[15];
    if (v[14:10] == '0) begin
      op.exp = '0;
      op.sig = '0;
    end else if (v[14:10] == '1) begin
      op.exp = FP16_MAX_POS[14:10];
      op.sig = {1'b1, FP16_MAX_POS[FP16_MAN_W-1:0], {FP16_GUARD_W{1'b0}}};
    end else begin
      op.exp = v[14:10];
      op.sig = {1'b1, v[FP16_MAN_W-1:0], {FP16_GUARD_W{1'b0}}};
    end
    return op;
  endfunction

endpackage

// File: rtl/fp16_accumulator_lzc.sv
// Leading-zero counter for the 15-bit raw sum; an all-zero input reports 15.
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [FP16_SUM_W-1:0] value,
  output logic [3:0]            count
);

  always_comb begin
    count = 4'(FP16_SUM_W);
    for (int i = 0; i < FP16_SUM_W; i++) begin
      if (value[i]) count = 4'(FP16_SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_accumulator.sv
// Multi-cycle fp16 running-sum accumulator: align, add/subtract, normalize, with a result pulse on the last term.
module fp16_accumulator
  import fp16_pkg::*;
#(
  parameter int GUARD_W    = FP16_GUARD_W,
  parameter bit SAT_ON_OVF = 1'b1
)
(
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [15:0] acc_value,
  output logic        busy
);

  localparam int SIG_W = 1 + FP16_MAN_W + GUARD_W;
  localparam int SUM_W = SIG_W + 1;

  acc_state_t state_q, state_d;

  logic [15:0]      acc_q, prod_q, out_q;
  logic             last_q;
  logic             bigSign_q, smlSign_q;
  logic [4:0]       algnExp_q;
  logic [SIG_W-1:0] bigSig_q, smlSig_q;
  logic [SUM_W-1:0] sum_q;
  logic             sumSign_q;
  logic [4:0]       sumExp_q;

  logic accept;

  assign in_ready  = RESETn && (state_q == IDLE) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE) && !clear;
  assign out_data  = out_q;
  assign acc_value = acc_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = ALIGN;
        ALIGN:   state_d = ADD;
        ADD:     state_d = NORM;
        NORM:    state_d = last_q ? DONE : IDLE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The accumulator wins exponent ties, so equal exponents compare significands in ADD.
  fp16_op_t         opAcc, opProd, opBig, opSml;
  logic [4:0]       expDiff;
  logic [SIG_W-1:0] smlShifted;

  always_comb begin
    opAcc  = fp16_unpack(acc_q);
    opProd = fp16_unpack(prod_q);
    if (opAcc.exp >= opProd.exp) begin
      opBig = opAcc;
      opSml = opProd;
    end else begin
      opBig = opProd;
      opSml = opAcc;
    end
    expDiff    = opBig.exp - opSml.exp;
    smlShifted = (expDiff >= 5'(SIG_W)) ? '0 : (opSml.sig >> expDiff);
  end

  logic [SUM_W-1:0] addSum;
  logic             addSign;

  always_comb begin
    addSum  = '0;
    addSign = bigSign_q;
    if (bigSign_q == smlSign_q) begin
      addSum = {1'b0, bigSig_q} + {1'b0, smlSig_q};
    end else if (bigSig_q >= smlSig_q) begin
      addSum = {1'b0, bigSig_q} - {1'b0, smlSig_q};
    end else begin
      addSum  = {1'b0, smlSig_q} - {1'b0, bigSig_q};
      addSign = smlSign_q;
    end
  end

  // Shifting by the leading-zero count puts the hidden bit at the top; the carry case is lz==0.
  logic [3:0]        lz;
  logic [SUM_W-1:0]  normSig;
  logic signed [6:0] normExp;
  logic [15:0]       normResult;

  fp16_lzc u_lzc (
    .value (sum_q),
    .count (lz)
  );

  always_comb begin
    normSig = sum_q << lz;
    normExp = 7'(sumExp_q) + 7'sd1 - 7'(lz);
    if (sum_q == '0 || normExp <= 7'sd0) begin
      normResult = '0;
    end else if (normExp >= 7'sd31) begin
      normResult = SAT_ON_OVF ? {sumSign_q, FP16_MAX_POS[14:0]} : {sumSign_q, FP16_INF[14:0]};
    end else begin
      normResult = {sumSign_q, normExp[4:0], normSig[SUM_W-2 -: FP16_MAN_W]};
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc_q     <= '0;
      prod_q    <= '0;
      out_q     <= '0;
      last_q    <= 1'b0;
      bigSign_q <= 1'b0;
      smlSign_q <= 1'b0;
      algnExp_q <= '0;
      bigSig_q  <= '0;
      smlSig_q  <= '0;
      sum_q     <= '0;
      sumSign_q <= 1'b0;
      sumExp_q  <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else begin
      if (accept) begin
        prod_q <= in_data;
        last_q <= in_last;
      end
      if (state_q == ALIGN) begin
        bigSign_q <= opBig.sign;
        smlSign_q <= opSml.sign;
        algnExp_q <= opBig.exp;
        bigSig_q  <= opBig.sig;
        smlSig_q  <= smlShifted;
      end
      if (state_q == ADD) begin
        sum_q     <= addSum;
        sumSign_q <= addSign;
        sumExp_q  <= algnExp_q;
      end
      if (state_q == NORM) begin
        acc_q <= normResult;
        if (last_q) out_q <= normResult;
      end
      if (state_q == DONE) acc_q <= '0;
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Randomized and directed bench for fp16_accumulator against an integer reference of the fp16 summation rules.
module tb_fp16_accumulator;

  localparam bit SAT = 1'b1;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] acc_value;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] modelAcc = '0;

  fp16_accumulator #(.GUARD_W(3), .SAT_ON_OVF(SAT)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .acc_value (acc_value),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Effective exponent and signed significand (with three guard bits) as the datapath sees an input.
  function automatic int effExp(input logic [15:0] x);
    if (x[14:10] == 5'd0)  return 0;
    if (x[14:10] == 5'd31) return 30;
    return int'(x[14:10]);
  endfunction

  function automatic longint alignedSig(input logic [15:0] x, input int emax);
    longint m;
    int d;
    if (x[14:10] == 5'd0)       m = 0;
    else if (x[14:10] == 5'd31) m = 2047;
    else                        m = 1024 + longint'(x[9:0]);
    m = m * 8;
    d = emax - effExp(x);
    m = (d >= 14) ? 0 : m / (longint'(1) << d);
    return x[15] ? -m : m;
  endfunction

  // Reference sum: align on the larger exponent grid, exact integer add, then truncate to 10 mantissa bits.
  function automatic logic [15:0] refAdd(input logic [15:0] a, input logic [15:0] b);
    int emax, k, e;
    longint s, mag, mant;
    logic neg;
    emax = (effExp(a) > effExp(b)) ? effExp(a) : effExp(b);
    s = alignedSig(a, emax) + alignedSig(b, emax);
    if (s == 0) return 16'h0000;
    neg = (s < 0);
    mag = neg ? -s : s;
    k = 0;
    while ((mag >> (k + 1)) != 0) k++;
    e = emax + k - 13;
    mant = (k >= 10) ? (mag >> (k - 10)) : (mag << (10 - k));
    mant = mant - 1024;
    if (e <= 0)  return 16'h0000;
    if (e >= 31) return SAT ? {neg, 15'h7BFF} : {neg, 15'h7C00};
    return {neg, 5'(e), 10'(mant)};
  endfunction

  function automatic logic [15:0] randOperand();
    logic [15:0] v;
    int sel;
    sel = $urandom_range(0, 9);
    v = 16'($urandom);
    if (sel < 7)       v[14:10] = 5'($urandom_range(10, 20));
    else if (sel == 7) v[14:10] = 5'd0;
    else if (sel == 8) v[14:10] = 5'd31;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] wanted);
    checks++;
    assert (observed === wanted) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, wanted);
    end
  endtask

  // Offers one term at a negedge and follows it through to IDLE (or through DONE when last).
  task automatic applyStimulus(input logic [15:0] d, input logic l, input string tag);
    int waitCnt;
    logic [15:0] expAcc;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge CLK);
      waitCnt++;
    end
    checkOutput({tag, "_ready"}, {15'd0, in_ready}, 16'd1);
    expAcc = refAdd(modelAcc, d);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge CLK);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'($urandom);
    checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd1);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput({tag, "_early_valid"}, {15'd0, out_valid}, 16'd0);
    @(negedge CLK);
    checkOutput({tag, "_acc"}, acc_value, expAcc);
    checkOutput({tag, "_valid"}, {15'd0, out_valid}, {15'd0, l});
    if (l) begin
      checkOutput({tag, "_out"}, out_data, expAcc);
      @(negedge CLK);
      checkOutput({tag, "_pulse_end"}, {15'd0, out_valid}, 16'd0);
      checkOutput({tag, "_acc_cleared"}, acc_value, 16'h0000);
      modelAcc = '0;
    end else begin
      checkOutput({tag, "_idle"}, {15'd0, busy}, 16'd0);
      modelAcc = expAcc;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, {15'd0, in_ready}, 16'd0);
    checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd0);
    checkOutput({tag, "_valid"}, {15'd0, out_valid}, 16'd0);
    checkOutput({tag, "_out"}, out_data, 16'h0000);
    checkOutput({tag, "_acc"}, acc_value, 16'h0000);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge CLK);
    checkResetValues("reset");
    RESETn = 1'b1;
    @(negedge CLK);

    applyStimulus(16'h3C00, 1'b0, "tp1a");
    applyStimulus(16'h4000, 1'b1, "tp1b");
    checkOutput("tp1_const", out_data, 16'h4200);

    applyStimulus(16'h4200, 1'b0, "tp2a");
    applyStimulus(16'hC000, 1'b1, "tp2b");
    checkOutput("tp2_const", out_data, 16'h3C00);

    applyStimulus(16'h3C00, 1'b0, "tp3a");
    applyStimulus(16'hBC00, 1'b1, "tp3b");
    checkOutput("tp3_const", out_data, 16'h0000);

    applyStimulus(16'h6800, 1'b0, "tp4a");
    applyStimulus(16'h3C00, 1'b1, "tp4b");
    checkOutput("tp4_const", out_data, 16'h6800);

    applyStimulus(16'h7800, 1'b0, "tp5a");
    applyStimulus(16'h7800, 1'b1, "tp5b");
    checkOutput("tp5_const", out_data, 16'h7BFF);

    applyStimulus(16'h0001, 1'b1, "ftz");
    checkOutput("ftz_const", out_data, 16'h0000);
    applyStimulus(16'hFC00, 1'b1, "inf_in");
    checkOutput("inf_in_const", out_data, 16'hFBFF);

    // Abort an in-flight term during ADD while a competing product is offered.
    in_valid = 1'b1;
    in_data  = 16'h4000;
    in_last  = 1'b0;
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h5000;
    in_last  = 1'b1;
    checkOutput("clr_ready", {15'd0, in_ready}, 16'd0);
    @(negedge CLK);
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("clr_busy", {15'd0, busy}, 16'd0);
    checkOutput("clr_acc", acc_value, 16'h0000);
    checkOutput("clr_valid", {15'd0, out_valid}, 16'd0);
    modelAcc = '0;
    applyStimulus(16'h3C00, 1'b1, "clr_after");
    checkOutput("clr_after_const", out_data, 16'h3C00);

    for (int v = 0; v < 10; v++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int t = 0; t < len; t++)
        applyStimulus(randOperand(), logic'(t == len - 1), $sformatf("rnd%0d_%0d", v, t));
    end

    // Reset while the NORM step of a term is in progress.
    applyStimulus(16'h4400, 1'b0, "rst_pre");
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    in_last  = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    checkResetValues("rst_mid");
    @(negedge CLK);
    checkResetValues("rst_edge");
    RESETn = 1'b1;
    modelAcc = '0;
    @(negedge CLK);
    applyStimulus(16'h3C00, 1'b1, "rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
